stepper_step_decoder: RTL and testbench

//  Receive side of the step/dir interface: decodes an incoming STEP/DIR pulse train (from our stepper

---
 rtl/stepper_step_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_stepper_step_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_step_decoder.sv
// stepper_step_decoder: receive side of a STEP/DIR interface.
// Synchronises the pins, qualifies STEP pulses by minimum high time, and
// accumulates a signed position, a step strobe and the measured step period.
// It also flags DIR setup violations and counts rejected (too short) STEP pulses.
module stepper_step_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 2,
  parameter int unsigned DIR_SETUP   = 4,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_in_i,
  input  logic        dir_in_i,
  input  logic        pos_clear_i,
  input  logic        pos_load_i,
  input  logic [31:0] pos_load_val_i,
  input  logic        err_clear_i,
  output logic [31:0] position_o,
  output logic        step_pulse_o,
  output logic        step_dir_o,
  output logic [31:0] period_o,
  output logic        period_valid_o,
  output logic        moving_o,
  output logic        dir_err_o,
  output logic [7:0]  glitch_cnt_o
);

  localparam int unsigned HCW = $clog2(MIN_HIGH + 1);
  localparam int unsigned DCW = $clog2(DIR_SETUP + 1);
  localparam logic [HCW-1:0] HONE_C      = HCW'(32'd1);
  localparam logic [HCW-1:0] HLAST_C     = HCW'(MIN_HIGH - 32'd1);
  localparam logic [DCW-1:0] DONE_C      = DCW'(32'd1);
  localparam logic [DCW-1:0] DIR_SETUP_C = DCW'(DIR_SETUP);
  localparam logic [31:0]    TIMEOUT_C   = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_HIGH_CNT  = 2'd1,
    ST_HIGH_WAIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] step_sync_q;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic                   step_s;
  logic                   dir_s;
  state_e                 state_q, state_d;
  logic [HCW-1:0]         hcnt_q, hcnt_d;
  logic                   accept_s;
  logic                   rise_s;
  logic                   glitch_s;
  logic                   dir_prev_q;
  logic [DCW-1:0]         dcnt_q;
  logic [31:0]            pcnt_q;
  logic                   have_prev_q;

  assign step_s = step_sync_q[SYNC_STAGES-1];
  assign dir_s  = dir_sync_q[SYNC_STAGES-1];

  // Pin synchronisers: nothing downstream looks at the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_in_i};
      dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_in_i};
    end
  end

  // Pulse qualifier decode: rising edge, accept (MIN_HIGH-th high cycle) and glitch events.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    accept_s = 1'b0;
    rise_s   = 1'b0;
    glitch_s = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (step_s) begin
          rise_s = 1'b1;
          hcnt_d = HONE_C;
          if (MIN_HIGH == 32'd1) begin
            accept_s = 1'b1;
            state_d  = ST_HIGH_WAIT;
          end else begin
            state_d = ST_HIGH_CNT;
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH_CNT: begin
        if (step_s) begin
          hcnt_d = hcnt_q + HONE_C;
          if (hcnt_q == HLAST_C) begin
            accept_s = 1'b1;
            state_d  = ST_HIGH_WAIT;
          end else begin
            state_d = ST_HIGH_CNT;
          end
        end else begin
          glitch_s = 1'b1;
          state_d  = ST_LOW;
        end
      end
      ST_HIGH_WAIT: begin
        if (step_s) begin
          state_d = ST_HIGH_WAIT;
        end else begin
          state_d = ST_LOW;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  // Pulse qualifier state: long pulses park in HIGH_WAIT so they count only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOW;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // DIR stability counter: cycles since the synced DIR last changed, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_prev_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      dir_prev_q <= dir_s;
      if (dir_s != dir_prev_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q != DIR_SETUP_C) begin
        dcnt_q <= dcnt_q + DONE_C;
      end
    end
  end

  // Position accumulator and step strobe; clear/load override the step's position update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position_o   <= 32'd0;
      step_pulse_o <= 1'b0;
      step_dir_o   <= 1'b0;
    end else begin
      step_pulse_o <= accept_s;
      if (accept_s) begin
        step_dir_o <= dir_s;
      end
      if (pos_clear_i) begin
        position_o <= 32'd0;
      end else if (pos_load_i) begin
        position_o <= pos_load_val_i;
      end else if (accept_s) begin
        position_o <= dir_s ? (position_o - 32'd1) : (position_o + 32'd1);
      end
    end
  end

  // Period measurement and motion timeout; a timeout makes the next step a "first" step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q         <= 32'd0;
      period_o       <= 32'd0;
      period_valid_o <= 1'b0;
      moving_o       <= 1'b0;
      have_prev_q    <= 1'b0;
    end else if (accept_s) begin
      pcnt_q      <= 32'd1;
      moving_o    <= 1'b1;
      have_prev_q <= 1'b1;
      if (have_prev_q) begin
        period_o       <= pcnt_q;
        period_valid_o <= 1'b1;
      end
    end else begin
      if (pcnt_q != 32'hFFFF_FFFF) begin
        pcnt_q <= pcnt_q + 32'd1;
      end
      if (pcnt_q >= TIMEOUT_C) begin
        moving_o       <= 1'b0;
        period_valid_o <= 1'b0;
        have_prev_q    <= 1'b0;
      end
    end
  end

  // Error reporting: sticky DIR setup flag and saturating glitch counter; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_err_o    <= 1'b0;
      glitch_cnt_o <= 8'd0;
    end else if (err_clear_i) begin
      dir_err_o    <= 1'b0;
      glitch_cnt_o <= 8'd0;
    end else begin
      if (rise_s && ((dir_s != dir_prev_q) || (dcnt_q < DIR_SETUP_C))) begin
        dir_err_o <= 1'b1;
      end
      if (glitch_s && (glitch_cnt_o != 8'd255)) begin
        glitch_cnt_o <= glitch_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stepper_step_decoder.sv
// Bench for stepper_step_decoder: directed scenarios plus a randomized pulse
// train checked against a pulse-level model (position, dir, period, glitches).
module tb_stepper_step_decoder;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_in = 1'b0;
  logic        dir_in = 1'b0;
  logic        pos_clear = 1'b0;
  logic        pos_load = 1'b0;
  logic [31:0] pos_load_val = 32'd0;
  logic        err_clear = 1'b0;
  logic [31:0] position;
  logic        step_pulse;
  logic        step_dir;
  logic [31:0] period;
  logic        period_valid;
  logic        moving;
  logic        dir_err;
  logic [7:0]  glitch_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  stepper_step_decoder #(.SYNC_STAGES(2), .MIN_HIGH(2), .DIR_SETUP(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .step_in_i(step_in), .dir_in_i(dir_in),
    .pos_clear_i(pos_clear), .pos_load_i(pos_load), .pos_load_val_i(pos_load_val),
    .err_clear_i(err_clear), .position_o(position), .step_pulse_o(step_pulse),
    .step_dir_o(step_dir), .period_o(period), .period_valid_o(period_valid),
    .moving_o(moving), .dir_err_o(dir_err), .glitch_cnt_o(glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) pulse_cnt++;
  end

  task automatic pulse(input int h, input int l);
    step_in = 1'b1;
    repeat (h) @(negedge clk);
    step_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic strobe_clear_err();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic strobe_load(input logic [31:0] v);
    pos_load_val = v;
    pos_load = 1'b1;
    @(negedge clk);
    pos_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL reset_position got %h exp 0", position); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse got %b exp 0", step_pulse); end
    checks++; if (period !== 32'd0 || period_valid !== 1'b0) begin errors++; $display("FAIL reset_period got %h/%b exp 0/0", period, period_valid); end
    checks++; if (moving !== 1'b0 || dir_err !== 1'b0 || glitch_cnt !== 8'd0 || step_dir !== 1'b0) begin errors++; $display("FAIL reset_flags got mv=%b de=%b gc=%0d sd=%b exp all 0", moving, dir_err, glitch_cnt, step_dir); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    int c0;
    c0 = pulse_cnt;
    for (int i = 0; i < 10; i++) pulse(5, 15);
    checks++; if (position !== 32'd10) begin errors++; $display("FAIL basic_position got %0d exp 10", position); end
    checks++; if (pulse_cnt - c0 != 10) begin errors++; $display("FAIL basic_pulses got %0d exp 10", pulse_cnt - c0); end
    checks++; if (period !== 32'd20 || period_valid !== 1'b1) begin errors++; $display("FAIL basic_period got %0d/%b exp 20/1", period, period_valid); end
    checks++; if (moving !== 1'b1 || step_dir !== 1'b0 || dir_err !== 1'b0) begin errors++; $display("FAIL basic_flags got mv=%b sd=%b de=%b exp 1/0/0", moving, step_dir, dir_err); end
  endtask

  task automatic test_wrap();
    strobe_load(32'h7FFF_FFFF);
    checks++; if (position !== 32'h7FFF_FFFF) begin errors++; $display("FAIL wrap_load got %h exp 7fffffff", position); end
    pulse(5, 15);
    checks++; if (position !== 32'h8000_0000) begin errors++; $display("FAIL wrap_up got %h exp 80000000", position); end
    dir_in = 1'b1;
    repeat (10) @(negedge clk);
    strobe_load(32'h0000_0000);
    pulse(5, 15);
    checks++; if (position !== 32'hFFFF_FFFF || step_dir !== 1'b1) begin errors++; $display("FAIL wrap_down got %h/%b exp ffffffff/1", position, step_dir); end
    dir_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [31:0] p0;
    int c0;
    strobe_clear_err();
    p0 = position;
    c0 = pulse_cnt;
    for (int i = 0; i < 3; i++) pulse(1, 10);
    checks++; if (glitch_cnt !== 8'd3) begin errors++; $display("FAIL glitch_count got %0d exp 3", glitch_cnt); end
    checks++; if (position !== p0 || pulse_cnt != c0) begin errors++; $display("FAIL glitch_no_step got pos %h pulses %0d exp %h 0", position, pulse_cnt - c0, p0); end
    strobe_clear_err();
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL glitch_clear got %0d exp 0", glitch_cnt); end
    for (int i = 0; i < 260; i++) pulse(1, 5);
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("FAIL glitch_saturate got %0d exp 255", glitch_cnt); end
    strobe_clear_err();
  endtask

  task automatic test_dir_setup();
    logic [31:0] p0;
    strobe_clear_err();
    p0 = position;
    dir_in = 1'b1;
    repeat (2) @(negedge clk);
    pulse(5, 15);
    checks++; if (dir_err !== 1'b1) begin errors++; $display("FAIL dirsetup_late got %b exp 1", dir_err); end
    checks++; if (position !== p0 - 32'd1 || step_dir !== 1'b1) begin errors++; $display("FAIL dirsetup_late_step got %h/%b exp %h/1", position, step_dir, p0 - 32'd1); end
    strobe_clear_err();
    dir_in = 1'b0;
    repeat (10) @(negedge clk);
    pulse(5, 15);
    checks++; if (dir_err !== 1'b0 || position !== p0 || step_dir !== 1'b0) begin errors++; $display("FAIL dirsetup_ok got de=%b pos=%h sd=%b exp 0/%h/0", dir_err, position, step_dir, p0); end
  endtask

  task automatic test_timeout();
    pulse(5, 15);
    pulse(5, 15);
    checks++; if (period !== 32'd20 || period_valid !== 1'b1 || moving !== 1'b1) begin errors++; $display("FAIL timeout_pre got %0d/%b/%b exp 20/1/1", period, period_valid, moving); end
    repeat (TO + 50) @(negedge clk);
    checks++; if (moving !== 1'b0 || period_valid !== 1'b0) begin errors++; $display("FAIL timeout_idle got mv=%b pv=%b exp 0/0", moving, period_valid); end
    pulse(5, 27);
    checks++; if (moving !== 1'b1 || period_valid !== 1'b0 || period !== 32'd20) begin errors++; $display("FAIL timeout_first got mv=%b pv=%b per=%0d exp 1/0/20", moving, period_valid, period); end
    pulse(5, 15);
    checks++; if (period_valid !== 1'b1 || period !== 32'd32) begin errors++; $display("FAIL timeout_second got pv=%b per=%0d exp 1/32", period_valid, period); end
  endtask

  task automatic test_random();
    logic [31:0] mpos;
    logic [31:0] mperiod;
    int mglitch, since, h, l;
    logic mdir, mhave, mvalid, g, prev_g, d;
    repeat (TO + 50) @(negedge clk);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    strobe_clear_err();
    mpos = 32'd0; mperiod = 32'd0; mglitch = 0; since = 0;
    mdir = 1'b0; mhave = 1'b0; mvalid = 1'b0; prev_g = 1'b0;
    for (int it = 0; it < 30; it++) begin
      d = 1'($urandom_range(0, 1));
      dir_in = d;
      repeat (10) @(negedge clk);
      since += 10;
      g = !prev_g && ($urandom_range(0, 4) == 0);
      h = g ? 1 : int'($urandom_range(2, 6));
      l = int'($urandom_range(8, 30));
      if (g) begin
        mglitch++;
      end else begin
        mpos = d ? mpos - 32'd1 : mpos + 32'd1;
        mdir = d;
        if (mhave) mperiod = since;
        mvalid = mhave;
        mhave = 1'b1;
        since = 0;
      end
      pulse(h, l);
      since += h + l;
      prev_g = g;
      checks++; if (position !== mpos || glitch_cnt !== 8'(mglitch)) begin errors++; $display("FAIL rand_pos it=%0d got %h gc=%0d exp %h gc=%0d", it, position, glitch_cnt, mpos, mglitch); end
      checks++; if (moving !== mhave || period_valid !== mvalid) begin errors++; $display("FAIL rand_flags it=%0d got mv=%b pv=%b exp %b/%b", it, moving, period_valid, mhave, mvalid); end
      if (mhave) begin
        checks++; if (step_dir !== mdir || dir_err !== 1'b0) begin errors++; $display("FAIL rand_dir it=%0d got sd=%b de=%b exp %b/0", it, step_dir, dir_err, mdir); end
      end
      if (mvalid) begin
        checks++; if (period !== mperiod) begin errors++; $display("FAIL rand_period it=%0d got %0d exp %0d", it, period, mperiod); end
      end
    end
    dir_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [31:0] v;
    strobe_load(32'd5);
    step_in = 1'b1;
    repeat (3) @(negedge clk);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    checks++; if (step_pulse !== 1'b1 || position !== 32'd0) begin errors++; $display("FAIL prio_clear got sp=%b pos=%h exp 1/0", step_pulse, position); end
    step_in = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL prio_clear_hold got %h exp 0", position); end
    v = $urandom;
    step_in = 1'b1;
    repeat (3) @(negedge clk);
    pos_load_val = v;
    pos_load = 1'b1;
    @(negedge clk);
    pos_load = 1'b0;
    checks++; if (step_pulse !== 1'b1 || position !== v) begin errors++; $display("FAIL prio_load got sp=%b pos=%h exp 1/%h", step_pulse, position, v); end
    step_in = 1'b0;
    repeat (15) @(negedge clk);
    strobe_clear_err();
    pulse(1, 10);
    step_in = 1'b1;
    @(negedge clk);
    step_in = 1'b0;
    repeat (2) @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL prio_errclear got %0d exp 0", glitch_cnt); end
  endtask

  task automatic test_reset_mid();
    strobe_load(32'h1234_5678);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (position !== 32'd0 || period !== 32'd0 || period_valid !== 1'b0 || moving !== 1'b0) begin errors++; $display("FAIL midrst_outputs got pos=%h per=%0d pv=%b mv=%b exp 0", position, period, period_valid, moving); end
    checks++; if (step_pulse !== 1'b0 || step_dir !== 1'b0 || dir_err !== 1'b0 || glitch_cnt !== 8'd0) begin errors++; $display("FAIL midrst_flags got sp=%b sd=%b de=%b gc=%0d exp 0", step_pulse, step_dir, dir_err, glitch_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL midrst_early got %h exp 0", position); end
    @(negedge clk);
    checks++; if (position !== 32'd1 || step_pulse !== 1'b1) begin errors++; $display("FAIL midrst_accept got pos=%h sp=%b exp 1/1", position, step_pulse); end
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (position !== 32'd1) begin errors++; $display("FAIL midrst_once got %h exp 1", position); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_glitch();
    test_dir_setup();
    test_timeout();
    test_random();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
